pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 16'hFFFC: address of reset vector low byte; high byte at RESET_VEC+1.
REQ-002 SHALL have parameter NMI_VEC, default 16'hFFFA: NMI vector low-byte address; high byte at NMI_VEC+1.
REQ-003 SHALL have parameter IRQ_VEC, default 16'hFFFE: IRQ/BRK vector low-byte address; high byte at IRQ_VEC+1.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port mem_rdata  in  8  memory read data, valid when mem_ready=1.
REQ-007 SHALL have port mem_ready  in  1  memory read completes this cycle.
REQ-008 SHALL have port fetch  in  1  current PC byte consumed; advance PC by 1.
REQ-009 SHALL have port jump_req  in  1  load PC from jump_addr.
REQ-010 SHALL have port jump_addr  in  16  absolute jump target.
REQ-011 SHALL have port branch_req  in  1  taken relative branch.
REQ-012 SHALL have port branch_offset  in  8  signed two's-complement branch offset.
REQ-013 SHALL have port vector_req  in  1  start a vector fetch.
REQ-014 SHALL have port vector_sel  in  2  0=reset, 1=NMI, 2=IRQ, 3=IRQ.
REQ-015 SHALL have port pc  out  16  current program counter.
REQ-016 SHALL have port mem_addr  out  16  memory read address; equals pc except in vector states.
REQ-017 SHALL have port mem_rd  out  1  vector read request, high only in VEC_LO and VEC_HI.
REQ-018 SHALL have port busy  out  1  high in any state other than RUN; requests are ignored while high.
REQ-019 SHALL have port op_done  out  1  one-cycle pulse the cycle after pc takes its final value for a jump, branch or vector operation.

Function
REQ-020 SHALL implement states VEC_LO, VEC_HI, RUN, BR_FIX; all outputs are registered or decoded from registered state only.
REQ-021 In RUN, requests sampled at the same edge SHALL be prioritised vector_req > jump_req > branch_req > fetch; lower-priority requests that cycle are dropped.
REQ-022 fetch in RUN SHALL set pc to pc+1 modulo 2^16 (16'hFFFF wraps to 16'h0000); stay in RUN.
REQ-023 jump_req in RUN SHALL load pc=jump_addr at the next edge; op_done=1 the following cycle; stay in RUN.
REQ-024 branch_req in RUN SHALL compute the low sum {carry,lo}=pc[7:0]+branch_offset (unsigned) and load pc[7:0]=lo at the next edge.
REQ-025 If no page crossing (offset>=0 and carry=0, or offset<0 and carry=1), pc[15:8] SHALL remain unchanged; stay in RUN; op_done=1 next cycle.
REQ-026 On page crossing, next state SHALL be BR_FIX; in BR_FIX pc[15:8] SHALL be incremented (offset>=0) or decremented (offset<0) modulo 256; then return to RUN with op_done=1 the following cycle; total 2 cycles.
REQ-027 vector_req in RUN SHALL enter VEC_LO with mem_addr = vector low-byte address selected by vector_sel; pc unchanged.
REQ-028 In VEC_LO, mem_rd=1; on mem_ready=1 SHALL latch mem_rdata as low byte and go to VEC_HI (mem_addr=vector+1); otherwise hold indefinitely.
REQ-029 In VEC_HI, mem_rd=1; on mem_ready=1 SHALL load pc={mem_rdata, latched low byte} and go to RUN; op_done=1 the following cycle.
REQ-030 fetch, jump_req, branch_req and vector_req SHALL be ignored in VEC_LO, VEC_HI and BR_FIX.
REQ-031 mem_ready outside VEC_LO/VEC_HI SHALL have no effect.

Reset
REQ-032 rst=1 at a clock edge SHALL override all activity, including mid-vector-fetch or BR_FIX, and set pc=16'h0000, op_done=0, latched low byte=8'h00, state=VEC_LO with mem_addr=RESET_VEC and mem_rd=1, busy=1.
REQ-033 After rst deasserts, the block SHALL perform the reset vector fetch of REQ-028/029 without any request input.

Verification
REQ-034 Reset then mem_ready with data 8'h00 at FFFC and 8'hC0 at FFFD -> mem_rd high for exactly those reads; pc=16'hC000, busy=0, op_done pulse once.
REQ-035 pc=16'hFFFF, fetch=1 -> pc=16'h0000 next cycle; busy stays 0.
REQ-036 pc=16'h10F0, branch_offset=8'h20 -> pc=16'h1010 after 1 cycle, busy=1, then 16'h1110, op_done; branch_offset=8'hF0 from 16'h1005 -> 16'h10F5 then 16'h0FF5.
REQ-037 pc=16'h2000, branch_offset=8'h7F -> pc=16'h207F in 1 cycle, no BR_FIX, op_done next cycle.
REQ-038 vector_req, jump_req, fetch together, vector_sel=1 -> jump and fetch dropped, mem_addr=16'hFFFA then 16'hFFFB; requests during busy ignored; pc loaded from NMI vector.
REQ-039 rst asserted during VEC_HI of an IRQ fetch -> pc=16'h0000, state VEC_LO, mem_addr=16'hFFFC next cycle; no op_done pulse.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between a control unit and the PC sequencer.
interface pc_sequencer_if;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        fetch;
  logic        jump_req;
  logic [15:0] jump_addr;
  logic        branch_req;
  logic [7:0]  branch_offset;
  logic        vector_req;
  logic [1:0]  vector_sel;
  logic [15:0] pc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        busy;
  logic        op_done;

  modport master (
    output mem_rdata, mem_ready, fetch, jump_req, jump_addr,
           branch_req, branch_offset, vector_req, vector_sel,
    input  pc, mem_addr, mem_rd, busy, op_done
  );

  modport slave (
    input  mem_rdata, mem_ready, fetch, jump_req, jump_addr,
           branch_req, branch_offset, vector_req, vector_sel,
    output pc, mem_addr, mem_rd, busy, op_done
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential fetch, absolute jump, relative
// branch with a page-crossing fix-up cycle, and two-byte vector loads.
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN, BR_FIX} state_t;

  state_t      state;
  logic [15:0] pc_r;
  logic [15:0] vec_addr;
  logic [7:0]  lo_byte;
  logic        br_neg;
  logic        done_pend;
  logic        op_done_r;

  logic [8:0]  br_sum;
  logic        br_cross;
  logic [15:0] sel_vec;

  // Low-byte branch sum and page-crossing detection from the carry and offset sign.
  always_comb begin
    br_sum   = {1'b0, pc_r[7:0]} + {1'b0, bus.branch_offset};
    br_cross = bus.branch_offset[7] ? ~br_sum[8] : br_sum[8];
  end

  // Vector low-byte address chosen by vector_sel.
  always_comb begin
    sel_vec = IRQ_VEC;
    case (bus.vector_sel)
      2'd0:    sel_vec = RESET_VEC;
      2'd1:    sel_vec = NMI_VEC;
      default: sel_vec = IRQ_VEC;
    endcase
  end

  assign bus.pc       = pc_r;
  assign bus.mem_addr = (state == VEC_LO) ? vec_addr :
                        (state == VEC_HI) ? vec_addr + 16'd1 : pc_r;
  assign bus.mem_rd   = (state == VEC_LO) || (state == VEC_HI);
  assign bus.busy     = (state != RUN);
  assign bus.op_done  = op_done_r;

  // Sequencer state, PC and completion strobe. op_done is delayed one cycle
  // behind the final PC update through done_pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= VEC_LO;
      pc_r      <= '0;
      lo_byte   <= '0;
      vec_addr  <= RESET_VEC;
      br_neg    <= 1'b0;
      done_pend <= 1'b0;
      op_done_r <= 1'b0;
    end else begin
      op_done_r <= done_pend;
      done_pend <= 1'b0;
      case (state)
        RUN: begin
          if (bus.vector_req) begin
            vec_addr <= sel_vec;
            state    <= VEC_LO;
          end else if (bus.jump_req) begin
            pc_r      <= bus.jump_addr;
            done_pend <= 1'b1;
          end else if (bus.branch_req) begin
            pc_r[7:0] <= br_sum[7:0];
            br_neg    <= bus.branch_offset[7];
            if (br_cross) state <= BR_FIX;
            else          done_pend <= 1'b1;
          end else if (bus.fetch) begin
            pc_r <= pc_r + 16'd1;
          end
        end
        BR_FIX: begin
          pc_r[15:8] <= br_neg ? pc_r[15:8] - 8'd1 : pc_r[15:8] + 8'd1;
          state      <= RUN;
          done_pend  <= 1'b1;
        end
        VEC_LO: begin
          if (bus.mem_ready) begin
            lo_byte <= bus.mem_rdata;
            state   <= VEC_HI;
          end
        end
        VEC_HI: begin
          if (bus.mem_ready) begin
            pc_r      <= {bus.mem_rdata, lo_byte};
            state     <= RUN;
            done_pend <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a transaction-level PC model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VEC (16'hFFFC),
    .NMI_VEC   (16'hFFFA),
    .IRQ_VEC   (16'hFFFE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_pc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch         = 1'b0;
    bus.jump_req      = 1'b0;
    bus.branch_req    = 1'b0;
    bus.vector_req    = 1'b0;
    bus.mem_ready     = 1'b0;
  endtask

  // Random request noise used while the sequencer is busy.
  task automatic garbage();
    bus.fetch         = 1'($urandom);
    bus.jump_req      = 1'($urandom);
    bus.jump_addr     = 16'($urandom);
    bus.branch_req    = 1'($urandom);
    bus.branch_offset = 8'($urandom);
    bus.vector_req    = 1'($urandom);
    bus.vector_sel    = 2'($urandom);
  endtask

  function automatic logic [15:0] vec_of(input logic [1:0] sel);
    if (sel == 2'd0) return 16'hFFFC;
    if (sel == 2'd1) return 16'hFFFA;
    return 16'hFFFE;
  endfunction

  task automatic check_run(input string tag);
    check({tag, "_pc"}, bus.pc, exp_pc);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_rd"}, bus.mem_rd, 1'b0);
    check({tag, "_addr"}, bus.mem_addr, exp_pc);
  endtask

  task automatic expect_done(input string tag);
    tick();
    check({tag, "_done"}, bus.op_done, 1'b1);
    check({tag, "_pc2"}, bus.pc, exp_pc);
  endtask

  // Services a vector read already in the low-byte phase.
  task automatic vec_service(input logic [15:0] vec, input logic [7:0] lo, input logic [7:0] hi);
    int unsigned w;
    w = $urandom_range(0, 2);
    for (int i = 0; i < int'(w); i++) begin
      garbage(); bus.mem_ready = 1'b0; bus.mem_rdata = 8'($urandom);
      tick();
      check("vlo_wait_addr", bus.mem_addr, vec);
      check("vlo_wait_rd", bus.mem_rd, 1'b1);
      check("vlo_wait_pc", bus.pc, exp_pc);
    end
    garbage(); bus.mem_ready = 1'b1; bus.mem_rdata = lo;
    tick();
    check("vhi_addr", bus.mem_addr, vec + 16'd1);
    check("vhi_rd", bus.mem_rd, 1'b1);
    check("vhi_busy", bus.busy, 1'b1);
    check("vhi_pc", bus.pc, exp_pc);
    w = $urandom_range(0, 2);
    for (int i = 0; i < int'(w); i++) begin
      garbage(); bus.mem_ready = 1'b0; bus.mem_rdata = 8'($urandom);
      tick();
      check("vhi_wait_addr", bus.mem_addr, vec + 16'd1);
      check("vhi_wait_pc", bus.pc, exp_pc);
    end
    garbage(); bus.mem_ready = 1'b1; bus.mem_rdata = hi;
    tick();
    idle();
    exp_pc = {hi, lo};
    check_run("vec_end");
    check("vec_end_nodone", bus.op_done, 1'b0);
    expect_done("vec");
  endtask

  task automatic op_reset(input logic [7:0] lo, input logic [7:0] hi);
    garbage(); rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    exp_pc = '0;
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_addr", bus.mem_addr, 16'hFFFC);
    check("rst_rd", bus.mem_rd, 1'b1);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_done", bus.op_done, 1'b0);
    vec_service(16'hFFFC, lo, hi);
  endtask

  task automatic op_fetch();
    idle(); bus.fetch = 1'b1; bus.mem_ready = 1'($urandom);
    tick();
    idle();
    exp_pc = exp_pc + 16'd1;
    check_run("fetch");
    check("fetch_done", bus.op_done, 1'b0);
  endtask

  task automatic op_jump(input logic [15:0] addr);
    idle(); bus.jump_req = 1'b1; bus.jump_addr = addr;
    bus.fetch = 1'($urandom); bus.branch_req = 1'($urandom);
    bus.branch_offset = 8'($urandom); bus.mem_ready = 1'($urandom);
    tick();
    idle();
    exp_pc = addr;
    check_run("jump");
    check("jump_nodone", bus.op_done, 1'b0);
    expect_done("jump");
  endtask

  task automatic op_branch(input logic [7:0] off);
    logic [15:0] target, inter;
    target = exp_pc + {{8{off[7]}}, off};
    inter  = {exp_pc[15:8], target[7:0]};
    idle(); bus.branch_req = 1'b1; bus.branch_offset = off;
    bus.fetch = 1'($urandom); bus.mem_ready = 1'($urandom);
    tick();
    idle();
    check("br_pc", bus.pc, inter);
    check("br_nodone", bus.op_done, 1'b0);
    if (target[15:8] != exp_pc[15:8]) begin
      check("br_fix_busy", bus.busy, 1'b1);
      garbage();
      tick();
      idle();
    end
    exp_pc = target;
    check_run("br_end");
    check("br_end_nodone", bus.op_done, 1'b0);
    expect_done("br");
  endtask

  task automatic op_vector(input logic [1:0] sel, input logic [7:0] lo, input logic [7:0] hi);
    idle(); bus.vector_req = 1'b1; bus.vector_sel = sel;
    bus.jump_req = 1'($urandom); bus.jump_addr = 16'($urandom);
    bus.fetch = 1'($urandom); bus.branch_req = 1'($urandom);
    tick();
    idle();
    check("vlo_addr", bus.mem_addr, vec_of(sel));
    check("vlo_rd", bus.mem_rd, 1'b1);
    check("vlo_busy", bus.busy, 1'b1);
    check("vlo_pc", bus.pc, exp_pc);
    vec_service(vec_of(sel), lo, hi);
  endtask

  task automatic op_reset_mid(input bit in_brfix);
    if (in_brfix) begin
      op_jump({8'($urandom), 8'hF0});
      idle(); bus.branch_req = 1'b1; bus.branch_offset = 8'h20;
      tick();
      check("mid_br_busy", bus.busy, 1'b1);
    end else begin
      idle(); bus.vector_req = 1'b1; bus.vector_sel = 2'd2;
      tick();
      idle(); bus.mem_ready = 1'b1; bus.mem_rdata = 8'($urandom);
      tick();
      check("mid_vhi_addr", bus.mem_addr, 16'hFFFF);
    end
    rst = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 8'($urandom);
    tick();
    rst = 1'b0; idle();
    exp_pc = '0;
    check("mid_rst_pc", bus.pc, 16'h0000);
    check("mid_rst_addr", bus.mem_addr, 16'hFFFC);
    check("mid_rst_busy", bus.busy, 1'b1);
    check("mid_rst_done", bus.op_done, 1'b0);
    tick();
    check("mid_rst_done2", bus.op_done, 1'b0);
    check("mid_rst_hold", bus.mem_addr, 16'hFFFC);
    vec_service(16'hFFFC, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_rdata = '0; bus.jump_addr = '0; bus.branch_offset = '0; bus.vector_sel = '0;
    idle();
    tick();
    // Reset vector to C000.
    op_reset(8'h00, 8'hC0);
    // Fetch wraps at FFFF.
    op_jump(16'hFFFF);
    op_fetch();
    // Forward and backward page-crossing branches, then in-page branch.
    op_jump(16'h10F0);
    op_branch(8'h20);
    op_jump(16'h1005);
    op_branch(8'hF0);
    op_jump(16'h2000);
    op_branch(8'h7F);
    // NMI with simultaneous jump and fetch.
    idle(); bus.vector_req = 1'b1; bus.vector_sel = 2'd1;
    bus.jump_req = 1'b1; bus.jump_addr = 16'h1234; bus.fetch = 1'b1;
    tick();
    idle();
    check("nmi_addr", bus.mem_addr, 16'hFFFA);
    check("nmi_pc", bus.pc, exp_pc);
    vec_service(16'hFFFA, 8'h34, 8'h89);
    check("nmi_final", bus.pc, 16'h8934);
    // Reset in the middle of an IRQ vector read and a branch fix-up.
    op_reset_mid(1'b0);
    op_reset_mid(1'b1);
    // Random operation mix.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op_fetch();
        3, 4:    op_jump(16'($urandom));
        5, 6, 7: op_branch(8'($urandom));
        8:       op_vector(2'($urandom), 8'($urandom), 8'($urandom));
        default: begin
          if ($urandom_range(0, 3) == 0) op_reset_mid(1'($urandom));
          else op_reset(8'($urandom), 8'($urandom));
        end
      endcase
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
